// File: rtl/axil_rr_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: round-robin, registered grant,
// one complete read (AR..R) or write (AW+W..B) transaction per grant.
module axil_rr_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // master 0 (IFU)
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    output logic [1:0]          m0_bresp,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    // master 1 (LSU)
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    // slave
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_RESP = 3'd2,
        WR_XFER = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   last_grant, last_grant_nxt;
    logic   aw_done, aw_done_nxt;
    logic   w_done, w_done_nxt;
    logic   req0, req1;
    logic   aw_all, w_all;

    assign req0 = m0_arvalid | m0_awvalid;
    assign req1 = m1_arvalid | m1_awvalid;
    assign busy = (state != IDLE);

    // State register; last_grant resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
        end
    end

    // Next-state, arbitration and write-phase bookkeeping.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        aw_done_nxt    = aw_done;
        w_done_nxt     = w_done;
        aw_all         = aw_done | (s_awvalid & s_awready);
        w_all          = w_done | (s_wvalid & s_wready);
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant_nxt      = (req0 & req1) ? ~last_grant : req1;
                    last_grant_nxt = grant_nxt;
                    state_nxt      = (grant_nxt ? m1_arvalid : m0_arvalid) ? RD_ADDR : WR_XFER;
                end
            end
            RD_ADDR: if (s_arvalid & s_arready) state_nxt = RD_RESP;
            RD_RESP: if (s_rvalid & s_rready) state_nxt = IDLE;
            WR_XFER: begin
                if (aw_all & w_all) begin
                    state_nxt   = WR_RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end else begin
                    aw_done_nxt = aw_all;
                    w_done_nxt  = w_all;
                end
            end
            WR_RESP: if (s_bvalid & s_bready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Channel routing: only the granted master's channel for the current phase is connected.
    always_comb begin
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_bresp   = 2'b00;
        m0_bvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;
        case (state)
            RD_ADDR: begin
                s_araddr  = grant ? m1_araddr : m0_araddr;
                s_arvalid = grant ? m1_arvalid : m0_arvalid;
                if (grant) m1_arready = s_arready;
                else       m0_arready = s_arready;
            end
            RD_RESP: begin
                s_rready = grant ? m1_rready : m0_rready;
                if (grant) begin
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rvalid = s_rvalid;
                end else begin
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rvalid = s_rvalid;
                end
            end
            WR_XFER: begin
                // A channel that already handshook is gated until the next write.
                if (!aw_done) begin
                    s_awaddr  = grant ? m1_awaddr : m0_awaddr;
                    s_awvalid = grant ? m1_awvalid : m0_awvalid;
                    if (grant) m1_awready = s_awready;
                    else       m0_awready = s_awready;
                end
                if (!w_done) begin
                    s_wdata  = grant ? m1_wdata : m0_wdata;
                    s_wstrb  = grant ? m1_wstrb : m0_wstrb;
                    s_wvalid = grant ? m1_wvalid : m0_wvalid;
                    if (grant) m1_wready = s_wready;
                    else       m0_wready = s_wready;
                end
            end
            WR_RESP: begin
                s_bready = grant ? m1_bready : m0_bready;
                if (grant) begin
                    m1_bresp  = s_bresp;
                    m1_bvalid = s_bvalid;
                end else begin
                    m0_bresp  = s_bresp;
                    m0_bvalid = s_bvalid;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Bench for axil_rr_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_axil_rr_arbiter;

    logic clk;
    logic rst;

    logic [1:0][31:0] araddr, rdata, awaddr, wdata;
    logic [1:0][3:0]  wstrb;
    logic [1:0][1:0]  rresp, bresp;
    logic [1:0]       arvalid, arready, rvalid, rready;
    logic [1:0]       awvalid, awready, wvalid, wready, bvalid, bready;

    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_rresp, s_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        busy;

    int total;
    int bad;
    int model_last;
    int pend [2];

    axil_rr_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(araddr[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
        .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
        .m0_awaddr(awaddr[0]), .m0_awvalid(awvalid[0]), .m0_awready(awready[0]),
        .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wvalid(wvalid[0]), .m0_wready(wready[0]),
        .m0_bresp(bresp[0]), .m0_bvalid(bvalid[0]), .m0_bready(bready[0]),
        .m1_araddr(araddr[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
        .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
        .m1_awaddr(awaddr[1]), .m1_awvalid(awvalid[1]), .m1_awready(awready[1]),
        .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wvalid(wvalid[1]), .m1_wready(wready[1]),
        .m1_bresp(bresp[1]), .m1_bvalid(bvalid[1]), .m1_bready(bready[1]),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit req(input int i);
        return arvalid[i] | awvalid[i];
    endfunction

    // Round-robin rule: a lone requester wins; on a tie the master not granted last time wins.
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return 1 - model_last;
        if (r1) return 1;
        return 0;
    endfunction

    // One read for master m; called in an IDLE cycle with m's arvalid already driven.
    task automatic rd(input int m, input logic [31:0] d, input logic [1:0] rs,
                      input int ar_lat, input int r_lat, input int bp);
        int o;
        o = 1 - m;
        #1;
        chk("idle_no_fwd", {s_arvalid, s_awvalid, s_wvalid}, 0);
        chk("idle_busy", busy, 0);
        @(negedge clk); #1;
        chk("rd_busy", busy, 1);
        chk("rd_arvalid", s_arvalid, 1);
        chk("rd_grant_addr", s_araddr, araddr[m]);
        chk("rd_no_aw", s_awvalid, 0);
        repeat (ar_lat) begin
            chk("ar_wait_ready", arready[m], 0);
            @(negedge clk); #1;
        end
        s_arready = 1'b1; #1;
        chk("arready_pass", arready[m], 1);
        chk("other_arready", arready[o], 0);
        @(negedge clk);
        s_arready = 1'b0; arvalid[m] = 1'b0; #1;
        chk("rresp_no_ar", s_arvalid, 0);
        repeat (r_lat) begin
            chk("r_wait_busy", busy, 1);
            @(negedge clk); #1;
        end
        s_rvalid = 1'b1; s_rdata = d; s_rresp = rs; rready[m] = 1'b0; #1;
        repeat (bp) begin
            chk("bp_srready", s_rready, 0);
            chk("bp_rvalid", rvalid[m], 1);
            chk("bp_other_arready", arready[o], 0);
            chk("bp_busy", busy, 1);
            @(negedge clk); #1;
        end
        rready[m] = 1'b1; #1;
        chk("rdata", rdata[m], d);
        chk("rresp", rresp[m], rs);
        chk("rvalid_other", rvalid[o], 0);
        chk("srready", s_rready, 1);
        @(negedge clk);
        s_rvalid = 1'b0; s_rdata = '0; rready[m] = 1'b0;
        model_last = m;
    endtask

    // One write for master m; AW handshakes in loop cycle aw_lat, W in cycle w_lat.
    task automatic wr(input int m, input int aw_lat, input int w_lat, input int b_lat,
                      input logic [1:0] bs);
        int o, n, awh, wh;
        o = 1 - m; awh = 0; wh = 0;
        n = ((aw_lat > w_lat) ? aw_lat : w_lat) + 1;
        #1;
        chk("idle_no_fwd", {s_arvalid, s_awvalid, s_wvalid}, 0);
        chk("idle_busy", busy, 0);
        @(negedge clk); #1;
        chk("wr_busy", busy, 1);
        chk("wr_awaddr", s_awaddr, awaddr[m]);
        chk("wr_wdata", s_wdata, wdata[m]);
        chk("wr_wstrb", s_wstrb, wstrb[m]);
        for (int c = 0; c < n; c++) begin
            s_awready = (c == aw_lat); s_wready = (c == w_lat); #1;
            chk("aw_gate", s_awvalid, c <= aw_lat);
            chk("w_gate", s_wvalid, c <= w_lat);
            chk("awready_pass", awready[m], c == aw_lat);
            chk("wready_pass", wready[m], c == w_lat);
            chk("other_wready", {awready[o], wready[o]}, 0);
            if (s_awvalid && s_awready) awh++;
            if (s_wvalid && s_wready) wh++;
            @(negedge clk);
            s_awready = 1'b0; s_wready = 1'b0; #1;
        end
        awvalid[m] = 1'b0; wvalid[m] = 1'b0;
        chk("aw_hs_count", awh, 1);
        chk("w_hs_count", wh, 1);
        chk("wresp_no_fwd", {s_awvalid, s_wvalid}, 0);
        repeat (b_lat) begin
            chk("b_wait_busy", busy, 1);
            @(negedge clk); #1;
        end
        s_bvalid = 1'b1; s_bresp = bs; bready[m] = 1'b1; #1;
        chk("bvalid", bvalid[m], 1);
        chk("bresp", bresp[m], bs);
        chk("bvalid_other", bvalid[o], 0);
        chk("sbready", s_bready, 1);
        @(negedge clk);
        s_bvalid = 1'b0; bready[m] = 1'b0;
        model_last = m;
    endtask

    initial begin
        int e;
        total = 0; bad = 0; model_last = 1;
        pend[0] = 0; pend[1] = 0;
        rst = 1'b0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        arvalid = '0; rready = '0; awvalid = '0; wvalid = '0; bready = '0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b1;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b1;

        // reset state, with stray slave responses present
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", {s_rready, s_bready}, 0);
        chk("rst_m_valid", {rvalid, bvalid}, 0);
        chk("rst_s_valid", {s_arvalid, s_awvalid, s_wvalid}, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("stray_resp_blocked", {rvalid, bvalid, s_rready, s_bready}, 0);
        s_rvalid = 1'b0; s_bvalid = 1'b0;

        // single read from master 0
        araddr[0] = 32'h8000_0000; arvalid[0] = 1'b1;
        rd(pick(req(0), req(1)), 32'hDEAD_BEEF, 2'b00, 0, 2, 0);

        // master 1 write, slave takes W three cycles before AW
        awaddr[1] = 32'h1000_0000; wdata[1] = 32'h41; wstrb[1] = 4'h1;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        wr(pick(req(0), req(1)), 3, 0, 1, 2'b00);

        // tie: both masters keep re-requesting reads
        araddr[0] = 32'h8000_0010; araddr[1] = 32'h9000_0020;
        arvalid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            e = pick(req(0), req(1));
            rd(e, 32'hA000_0000 + 32'(i), 2'b00, i % 2, 1, 0);
            if (i < 3) arvalid[e] = 1'b1;
        end
        arvalid = '0;

        // read beats write inside master 1, then the write follows
        araddr[1] = 32'h9000_0100; awaddr[1] = 32'h1000_0200;
        wdata[1] = 32'h1234_5678; wstrb[1] = 4'hF;
        arvalid[1] = 1'b1; awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        rd(pick(req(0), req(1)), 32'h0BAD_F00D, 2'b01, 0, 0, 0);
        wr(pick(req(0), req(1)), 0, 0, 0, 2'b11);

        // R backpressure on master 0 while master 1 waits; SLVERR passes through
        araddr[0] = 32'h8000_0300; araddr[1] = 32'h9000_0304;
        arvalid = 2'b11;
        rd(pick(req(0), req(1)), 32'hCAFE_0001, 2'b10, 1, 0, 5);
        rd(pick(req(0), req(1)), 32'hCAFE_0002, 2'b00, 0, 0, 0);

        // asynchronous reset while in RD_RESP
        araddr[0] = 32'h8000_0400; arvalid[0] = 1'b1;
        @(negedge clk);
        s_arready = 1'b1;
        @(negedge clk);
        arvalid[0] = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA; #1;
        chk("pre_rst_rvalid", rvalid[0], 1);
        #1 rst = 1'b0; #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_outs", {rvalid, s_rready, s_arvalid, rdata[0]}, 0);
        @(negedge clk);
        rst = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
        model_last = 1;
        araddr[1] = 32'h9000_0500; arvalid[1] = 1'b1;
        rd(pick(req(0), req(1)), 32'h7777_0000, 2'b00, 0, 1, 0);

        // randomized traffic from both masters
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 1) == 1) begin
                    pend[i] = int'($urandom_range(1, 2));
                    if (pend[i] == 1) begin
                        araddr[i] = {$urandom} & 32'hFFFF_FFFE | 32'(i);
                        arvalid[i] = 1'b1;
                    end else begin
                        awaddr[i] = {$urandom} & 32'hFFFF_FFFE | 32'(i);
                        wdata[i] = $urandom;
                        wstrb[i] = 4'($urandom);
                        awvalid[i] = 1'b1; wvalid[i] = 1'b1;
                    end
                end
            end
            if (pend[0] == 0 && pend[1] == 0) begin
                pend[0] = 1;
                araddr[0] = {$urandom} & 32'hFFFF_FFFE;
                arvalid[0] = 1'b1;
            end
            e = pick(pend[0] != 0, pend[1] != 0);
            if (pend[e] == 1)
                rd(e, $urandom, 2'($urandom), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            else
                wr(e, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), 2'($urandom));
            pend[e] = 0;
        end

        arvalid = '0; awvalid = '0; wvalid = '0;
        @(negedge clk); #1;
        chk("final_idle", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
